// File: rtl/tpu_package.sv
// Shared TPU constants, drain FSM states and the requantization helper.
package tpu_package;

  localparam int MUL_SIZE   = 4;
  localparam int RES_WIDTH  = 31;
  localparam int DATA_WIDTH = 8;
  localparam int ACC_ROWS   = 128;

  localparam int QW   = RES_WIDTH + 2;
  localparam int QMAX = 2 ** (DATA_WIDTH - 1) - 1;
  localparam int QMIN = -(2 ** (DATA_WIDTH - 1));

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    FLUSH
  } drain_state_t;

  // ReLU, round-half-up right shift, saturate to DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] quantize(
    input logic [RES_WIDTH:0] v,
    input logic [4:0]         sh,
    input logic               relu
  );
    logic signed [QW-1:0] x;
    logic signed [QW-1:0] rnd;
    logic signed [QW-1:0] r;
    logic signed [QW-1:0] hi;
    logic signed [QW-1:0] lo;
    logic [DATA_WIDTH-1:0] res;
    x = {v[RES_WIDTH], v};
    if (relu && v[RES_WIDTH]) x = '0;
    rnd = '0;
    if (sh != 5'd0) rnd = QW'(1) << (sh - 5'd1);
    r  = (x + rnd) >>> sh;
    hi = QW'(QMAX);
    lo = QW'(QMIN);
    if (r > hi)      res = DATA_WIDTH'(QMAX);
    else if (r < lo) res = DATA_WIDTH'(QMIN);
    else             res = r[DATA_WIDTH-1:0];
    return res;
  endfunction

endpackage

// File: rtl/drain_fifo.sv
// Synchronous FIFO; the head entry is held in a register so the
// output is flop-driven and stable until popped.
module drain_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 128
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    rd_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] head_q;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    rd_d = rd_q;
    if (pop_i) rd_d = inc(rd_q);
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_q] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      if (push_i) wr_q <= inc(wr_q);
      rd_q  <= rd_d;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
      // New head is the word being written when nothing else remains.
      if (push_i && cnt_q == CW'(pop_i)) head_q <= din_i;
      else if (pop_i)                    head_q <= mem[rd_d];
    end
  end

  assign dout_o  = head_q;
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/accum_drain.sv
// Accumulator tile drain: burst read, lane de-skew, ReLU/requantize,
// and a FIFO-buffered row stream toward the unified buffer.
module accum_drain
  import tpu_package::*;
#(
  parameter int FIFO_DEPTH = 128
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  start_i,
  input  logic [6:0]                            base_addr_i,
  input  logic [7:0]                            rows_i,
  input  logic [4:0]                            shift_i,
  input  logic                                  relu_en_i,
  output logic                                  ready_o,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic                                  acc_rd_en_o,
  output logic [9:0]                            acc_addr_rd_o,
  input  logic [MUL_SIZE-1:0][RES_WIDTH:0]      acc_data_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [MUL_SIZE-1:0][DATA_WIDTH-1:0]   out_data_o,
  output logic                                  out_last_o
);

  localparam int KW = $clog2(ACC_ROWS + MUL_SIZE);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = MUL_SIZE * DATA_WIDTH + 1;

  drain_state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d, last_k;
  logic [6:0]    base_q;
  logic [7:0]    rows_q;
  logic [4:0]    shift_q;
  logic          relu_q;
  logic          zdone_q;
  logic          tok1_v_q, tok1_last_q;
  logic          tok2_v_q, tok2_last_q;
  logic [MUL_SIZE-1:0][DATA_WIDTH-1:0] qrow_q;
  logic [MUL_SIZE-1:0][RES_WIDTH:0]    aligned;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_empty, fifo_full;
  logic [FW-1:0] fifo_dout;
  logic          accept, issue, push, pop;

  assign issue   = (state_q == ISSUE);
  assign last_k  = KW'(rows_q) + KW'(MUL_SIZE - 2);
  assign ready_o = (state_q == IDLE) &&
                   ((FIFO_DEPTH - int'(fifo_cnt)) >= int'(rows_i));
  assign accept  = start_i && ready_o;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (accept && rows_i != 8'd0) begin
          state_d = ISSUE;
          k_d     = '0;
        end
      end
      ISSUE: begin
        k_d = k_q + KW'(1);
        if (k_q == last_k) begin
          state_d = FLUSH;
          k_d     = '0;
        end
      end
      FLUSH: begin
        k_d = k_q + KW'(1);
        if (k_q == KW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      k_q         <= '0;
      base_q      <= '0;
      rows_q      <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      zdone_q     <= 1'b0;
      tok1_v_q    <= 1'b0;
      tok1_last_q <= 1'b0;
      tok2_v_q    <= 1'b0;
      tok2_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      zdone_q <= accept && (rows_i == 8'd0);
      if (accept) begin
        base_q  <= base_addr_i;
        rows_q  <= rows_i;
        shift_q <= shift_i;
        relu_q  <= relu_en_i;
      end
      // Token lags its read by one cycle, matching the read latency.
      tok1_v_q    <= issue && (k_q >= KW'(MUL_SIZE - 1));
      tok1_last_q <= issue && (k_q == last_k);
      tok2_v_q    <= tok1_v_q;
      tok2_last_q <= tok1_last_q;
    end
  end

  for (genvar c = 0; c < MUL_SIZE; c++) begin : g_lane
    localparam int D = MUL_SIZE - 1 - c;
    if (D == 0) begin : g_pass
      assign aligned[c] = acc_data_i[c];
    end else begin : g_dly
      logic [RES_WIDTH:0] sr_q [D];
      always_ff @(posedge clk_i) begin
        sr_q[0] <= acc_data_i[c];
        for (int i = 1; i < D; i++) sr_q[i] <= sr_q[i-1];
      end
      assign aligned[c] = sr_q[D-1];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < MUL_SIZE; c++)
      qrow_q[c] <= quantize(aligned[c], shift_q, relu_q);
  end

  assign push = tok2_v_q && !fifo_full;
  assign pop  = out_valid_o && out_ready_i;

  drain_fifo #(
    .WIDTH(FW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push),
    .din_i  ({tok2_last_q, qrow_q}),
    .pop_i  (pop),
    .dout_o (fifo_dout),
    .count_o(fifo_cnt),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

  assign out_valid_o   = !fifo_empty;
  assign out_last_o    = fifo_dout[FW-1];
  assign out_data_o    = fifo_dout[FW-2:0];
  assign done_o        = (tok2_v_q && tok2_last_q) || zdone_q;
  assign busy_o        = (state_q != IDLE);
  assign acc_rd_en_o   = issue;
  assign acc_addr_rd_o = issue ? {3'b000, 7'(base_q + k_q[6:0])} : '0;

endmodule

// File: tb/tb_accum_drain.sv
// Scoreboard bench for accum_drain with a behavioural accumulator port.
module tb_accum_drain;
  import tpu_package::*;

  localparam int M  = MUL_SIZE;
  localparam int RW = RES_WIDTH + 1;
  localparam int EW = M * DATA_WIDTH + 1;

  logic clk;
  logic rst_i;
  logic start_i;
  logic [6:0] base_addr_i;
  logic [7:0] rows_i;
  logic [4:0] shift_i;
  logic relu_en_i;
  logic ready_o, busy_o, done_o, acc_rd_en_o;
  logic [9:0] acc_addr_rd_o;
  logic [M-1:0][RES_WIDTH:0] acc_data_i;
  logic out_valid_o, out_ready_i, out_last_o;
  logic [M-1:0][DATA_WIDTH-1:0] out_data_o;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [EW-1:0] sb [$];
  logic signed [RW-1:0] mem [ACC_ROWS][M];
  logic [EW-1:0] held;
  bit held_v = 0;
  int wrap_addr [7] = '{126, 127, 0, 1, 2, 3, 4};

  accum_drain #(.FIFO_DEPTH(128)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .rows_i       (rows_i),
    .shift_i      (shift_i),
    .relu_en_i    (relu_en_i),
    .ready_o      (ready_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .acc_rd_en_o  (acc_rd_en_o),
    .acc_addr_rd_o(acc_addr_rd_o),
    .acc_data_i   (acc_data_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .out_last_o   (out_last_o)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Lane c returns row (addr - c) mod 128 one cycle after the read.
  always @(posedge clk) begin
    for (int c = 0; c < M; c++) begin
      if (acc_rd_en_o)
        acc_data_i[c] <= mem[(int'(acc_addr_rd_o[6:0]) - c + ACC_ROWS) % ACC_ROWS][c];
      else
        acc_data_i[c] <= RW'(32'h5a5a_5a5a);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_i) begin
      held_v = 0;
    end else begin
      if (out_valid_o && !out_ready_i) begin
        if (held_v) chk("stall_stable", {out_last_o, out_data_o}, held);
        held   = {out_last_o, out_data_o};
        held_v = 1;
      end else begin
        held_v = 0;
      end
      if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_row actual=%0h required=none",
                   {out_last_o, out_data_o});
        end else begin
          chk("row", {out_last_o, out_data_o}, sb.pop_front());
        end
      end
      if (done_o) done_cnt++;
    end
  end

  function automatic logic [EW-1:0] mkrow(input bit last, input int v0, input int v1,
                                          input int v2, input int v3);
    return {last, 8'(v3), 8'(v2), 8'(v1), 8'(v0)};
  endfunction

  function automatic int pat(input int r, input int c);
    return (r % 12) * 10 + c;
  endfunction

  task automatic fill_pattern();
    for (int r = 0; r < ACC_ROWS; r++)
      for (int c = 0; c < M; c++)
        mem[r][c] = RW'(pat(r, c));
  endtask

  task automatic push_pat(input int base, input int rows);
    for (int j = 0; j < rows; j++) begin
      int r;
      r = (base + j) % ACC_ROWS;
      sb.push_back(mkrow(j == rows - 1, pat(r, 0), pat(r, 1), pat(r, 2), pat(r, 3)));
    end
  endtask

  task automatic do_start(input int base, input int rows, input int sh, input bit relu);
    bit ok;
    ok          = 0;
    start_i     = 1;
    base_addr_i = 7'(base);
    rows_i      = 8'(rows);
    shift_i     = 5'(sh);
    relu_en_i   = relu;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (ready_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL start_timeout actual=ready_low required=accept");
      start_i = 0;
      return;
    end
    @(posedge clk);
    #1 start_i = 0;
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !out_valid_o && !busy_o) begin
        ok = 1;
        break;
      end
    end
    chk(name, 64'(ok), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int wcnt;
    bit ok;
    rst_i       = 1;
    start_i     = 0;
    base_addr_i = '0;
    rows_i      = '0;
    shift_i     = '0;
    relu_en_i   = 0;
    out_ready_i = 1;
    fill_pattern();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_rd_en", acc_rd_en_o, 0);
    chk("rst_addr", acc_addr_rd_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_last", out_last_o, 0);
    chk("rst_data", out_data_o, 0);
    rst_i = 0;
    @(posedge clk);
    #1;

    // Basic drain with latency probes.
    d0 = done_cnt;
    push_pat(0, 4);
    do_start(0, 4, 0, 0);
    repeat (5) @(posedge clk);
    #1 chk("lat_valid_low", out_valid_o, 0);
    @(posedge clk);
    #1 chk("lat_valid_high", out_valid_o, 1);
    @(posedge clk);
    #1 chk("done_early", done_o, 0);
    @(posedge clk);
    #1 chk("done_on_time", done_o, 1);
    wait_drain("basic_drain");
    chk("basic_done_cnt", 64'(done_cnt - d0), 1);

    // Zero-row tile.
    d0 = done_cnt;
    do_start(5, 0, 0, 0);
    chk("zero_done", done_o, 1);
    chk("zero_rd_en", acc_rd_en_o, 0);
    chk("zero_busy", busy_o, 0);
    @(posedge clk);
    #1 chk("zero_done_once", done_o, 0);
    chk("zero_done_cnt", 64'(done_cnt - d0), 1);

    // Address wrap 126 -> 1.
    d0 = done_cnt;
    push_pat(126, 4);
    do_start(126, 4, 0, 0);
    for (int k = 0; k < 7; k++) begin
      chk("wrap_rd_en", acc_rd_en_o, 1);
      chk("wrap_addr", acc_addr_rd_o, 64'(wrap_addr[k]));
      @(posedge clk);
      #1;
    end
    chk("wrap_burst_end", acc_rd_en_o, 0);
    wait_drain("wrap_drain");
    chk("wrap_done_cnt", 64'(done_cnt - d0), 1);

    // Quantization corners.
    mem[40][0] = -300;  mem[40][1] = 5;   mem[40][2] = -1;    mem[40][3] = 0;
    mem[41][0] = 1000;  mem[41][1] = 6;   mem[41][2] = -6;    mem[41][3] = 5;
    mem[42][0] = -1000; mem[42][1] = 127; mem[42][2] = 128;   mem[42][3] = -128;
    mem[43][0] = -7;    mem[43][1] = 7;   mem[43][2] = 1000;  mem[43][3] = 2;
    sb.push_back(mkrow(1, 0, 5, 0, 0));
    do_start(40, 1, 0, 1);
    wait_drain("q_relu");
    sb.push_back(mkrow(1, 127, 2, -1, 1));
    do_start(41, 1, 2, 0);
    wait_drain("q_shift2");
    sb.push_back(mkrow(1, -128, 127, 127, -128));
    do_start(42, 1, 0, 0);
    wait_drain("q_sat");
    sb.push_back(mkrow(1, 0, 4, 127, 1));
    do_start(43, 1, 1, 1);
    wait_drain("q_relu_shift1");
    fill_pattern();

    // Backpressure during a 32-row drain.
    d0 = done_cnt;
    push_pat(60, 32);
    do_start(60, 32, 0, 0);
    repeat (12) @(posedge clk);
    #1 out_ready_i = 0;
    repeat (50) @(posedge clk);
    #1 out_ready_i = 1;
    wait_drain("bp_drain");
    chk("bp_done_cnt", 64'(done_cnt - d0), 1);

    // Admission: 100 rows parked, then a 64-row request.
    out_ready_i = 0;
    d0 = done_cnt;
    push_pat(0, 100);
    do_start(0, 100, 0, 0);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (done_cnt != d0) begin
        ok = 1;
        break;
      end
    end
    chk("adm_fill_done", 64'(ok), 1);
    push_pat(100, 64);
    start_i     = 1;
    base_addr_i = 7'd100;
    rows_i      = 8'd64;
    shift_i     = 5'd0;
    relu_en_i   = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("adm_blocked", ready_o, 0);
    end
    @(posedge clk);
    #1 out_ready_i = 1;
    wcnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready_o) break;
      wcnt++;
    end
    chk("adm_wait_cycles", 64'(wcnt), 36);
    @(posedge clk);
    #1 start_i = 0;
    wait_drain("adm_drain");
    chk("adm_done_cnt", 64'(done_cnt - d0), 2);

    // Reset while the burst is at k = 5.
    d0 = done_cnt;
    do_start(5, 20, 0, 0);
    repeat (5) @(posedge clk);
    #1 chk("rst_k5_addr", acc_addr_rd_o, 10);
    rst_i = 1;
    sb.delete();
    @(posedge clk);
    #1 rst_i = 0;
    chk("midrst_rd_en", acc_rd_en_o, 0);
    chk("midrst_valid", out_valid_o, 0);
    chk("midrst_ready", ready_o, 1);
    chk("midrst_busy", busy_o, 0);
    repeat (30) @(posedge clk);
    #1 chk("midrst_no_done", 64'(done_cnt - d0), 0);
    chk("midrst_still_empty", out_valid_o, 0);

    // Recovery after reset.
    push_pat(3, 2);
    do_start(3, 2, 0, 1);
    wait_drain("recover_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
